// File: rtl/ats_eligibility_gate.sv
// ATS per-queue transmission gate: pairs each frame with its eligibility time, holds it until
// the scheduler timer reaches that time, then releases it or drops it if residence is too long.
module ats_eligibility_gate #(
   parameter int unsigned     DATA_WIDTH         = 8,
   parameter int unsigned     TIMESTAMP_WIDTH    = 72,
   parameter longint unsigned MAX_RESIDENCE_TIME = 0,
   parameter int unsigned     COUNTER_WIDTH      = 32
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [TIMESTAMP_WIDTH-1:0] ats_scheduler_timer,
   input  logic                       enable,
   input  logic [TIMESTAMP_WIDTH-1:0] s_elig_tdata,
   input  logic                       s_elig_tvalid,
   output logic                       s_elig_tready,
   input  logic [DATA_WIDTH-1:0]      s_axis_tdata,
   input  logic                       s_axis_tvalid,
   output logic                       s_axis_tready,
   input  logic                       s_axis_tlast,
   output logic [DATA_WIDTH-1:0]      m_axis_tdata,
   output logic                       m_axis_tvalid,
   input  logic                       m_axis_tready,
   output logic                       m_axis_tlast,
   output logic [COUNTER_WIDTH-1:0]   pass_count,
   output logic [COUNTER_WIDTH-1:0]   drop_count,
   output logic                       busy
);

   // Residence compare is done at whichever width is wider, so no operand is truncated.
   localparam int unsigned CmpWidth = (TIMESTAMP_WIDTH > 64) ? TIMESTAMP_WIDTH : 64;

   typedef enum logic [1:0] {StIdle, StWait, StPass, StDrop} state_e;

   state_e                     state_q;
   logic [TIMESTAMP_WIDTH-1:0] elig_time_q;
   logic [COUNTER_WIDTH-1:0]   pass_q;
   logic [COUNTER_WIDTH-1:0]   drop_q;

   logic [TIMESTAMP_WIDTH-1:0] delta;
   logic [CmpWidth-1:0]        delta_ext;
   logic                       eligible;
   logic                       over_limit;
   logic                       last_hs;

   // Modular difference: MSB clear means timer is at or past elig_time within half the range.
   assign delta      = ats_scheduler_timer - elig_time_q;
   assign delta_ext  = CmpWidth'(delta);
   assign eligible   = ~delta[TIMESTAMP_WIDTH-1];
   assign over_limit = (MAX_RESIDENCE_TIME != 0) &&
                       (delta_ext > CmpWidth'(MAX_RESIDENCE_TIME));
   assign last_hs    = s_axis_tvalid & s_axis_tready & s_axis_tlast;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StIdle;
         elig_time_q <= '0;
         pass_q      <= '0;
         drop_q      <= '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (s_elig_tvalid && enable) begin
                  elig_time_q <= s_elig_tdata;
                  state_q     <= StWait;
               end
            end
            StWait: begin
               if (eligible) state_q <= over_limit ? StDrop : StPass;
            end
            StPass: begin
               if (last_hs) begin
                  state_q <= StIdle;
                  if (pass_q != '1) pass_q <= pass_q + COUNTER_WIDTH'(1);
               end
            end
            StDrop: begin
               if (last_hs) begin
                  state_q <= StIdle;
                  if (drop_q != '1) drop_q <= drop_q + COUNTER_WIDTH'(1);
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   always_comb begin
      s_elig_tready = 1'b0;
      s_axis_tready = 1'b0;
      m_axis_tdata  = '0;
      m_axis_tvalid = 1'b0;
      m_axis_tlast  = 1'b0;
      unique case (state_q)
         StIdle: s_elig_tready = enable;
         StPass: begin
            m_axis_tdata  = s_axis_tdata;
            m_axis_tvalid = s_axis_tvalid;
            m_axis_tlast  = s_axis_tlast;
            s_axis_tready = m_axis_tready;
         end
         StDrop: s_axis_tready = 1'b1;
         default: ;
      endcase
   end

   assign busy       = (state_q != StIdle);
   assign pass_count = pass_q;
   assign drop_count = drop_q;

endmodule

// File: tb/tb_ats_eligibility_gate.sv
// Directed and randomized bench for ats_eligibility_gate; a frame-level model predicts release
// time, pass/drop outcome, released beats and saturating counters.
module tb_ats_eligibility_gate;

   localparam int unsigned     DW   = 8;
   localparam int unsigned     TW   = 72;
   localparam longint unsigned MAXR = 64;
   localparam int unsigned     CW   = 2;
   localparam int unsigned     CMAX = (1 << CW) - 1;

   logic          clk = 1'b0;
   logic          rst;
   logic [TW-1:0] tmr;
   logic          enable;
   logic [TW-1:0] s_elig_tdata;
   logic          s_elig_tvalid;
   logic          s_elig_tready;
   logic [DW-1:0] s_axis_tdata;
   logic          s_axis_tvalid;
   logic          s_axis_tready;
   logic          s_axis_tlast;
   logic [DW-1:0] m_axis_tdata;
   logic          m_axis_tvalid;
   logic          m_axis_tready;
   logic          m_axis_tlast;
   logic [CW-1:0] pass_count;
   logic [CW-1:0] drop_count;
   logic          busy;

   int checks   = 0;
   int failures = 0;
   int exp_pass = 0;
   int exp_drop = 0;
   logic [TW-1:0] all1;

   ats_eligibility_gate #(
      .DATA_WIDTH        (DW),
      .TIMESTAMP_WIDTH   (TW),
      .MAX_RESIDENCE_TIME(MAXR),
      .COUNTER_WIDTH     (CW)
   ) dut (
      .clk                (clk),
      .rst                (rst),
      .ats_scheduler_timer(tmr),
      .enable             (enable),
      .s_elig_tdata       (s_elig_tdata),
      .s_elig_tvalid      (s_elig_tvalid),
      .s_elig_tready      (s_elig_tready),
      .s_axis_tdata       (s_axis_tdata),
      .s_axis_tvalid      (s_axis_tvalid),
      .s_axis_tready      (s_axis_tready),
      .s_axis_tlast       (s_axis_tlast),
      .m_axis_tdata       (m_axis_tdata),
      .m_axis_tvalid      (m_axis_tvalid),
      .m_axis_tready      (m_axis_tready),
      .m_axis_tlast       (m_axis_tlast),
      .pass_count         (pass_count),
      .drop_count         (drop_count),
      .busy               (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [TW-1:0] obs, input logic [TW-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Timer advances by one per clock; inputs change 1 time unit after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
      tmr = tmr + 1;
   endtask

   task automatic chk_counters(input string tag);
      chk({tag, "_pass_count"}, TW'(pass_count), TW'(exp_pass));
      chk({tag, "_drop_count"}, TW'(drop_count), TW'(exp_drop));
   endtask

   // One frame: offer the record, then keep the frame at the FIFO head until it is consumed.
   task automatic run_frame(input logic [TW-1:0] elig, input int nbeats, input bit rnd,
                            input bit kill_en);
      logic [DW:0]   sent[$];
      logic [DW:0]   got[$];
      logic [TW-1:0] t_wait, delta, first_t;
      bit            drop, active;
      int            idx, guard;
      for (int i = 0; i < nbeats; i++) sent.push_back({(i == nbeats - 1), DW'($urandom)});
      s_elig_tdata  = elig;
      s_elig_tvalid = 1'b1;
      #1;
      guard = 0;
      while (s_elig_tready !== 1'b1 && guard < 50) begin
         tick();
         guard++;
      end
      chk("elig_accept_bound", TW'(guard < 50), 1);
      tick();
      s_elig_tvalid = 1'b0;
      t_wait = tmr;
      #1;
      chk("wait_busy", TW'(busy), 1);
      chk("wait_elig_tready", TW'(s_elig_tready), 0);
      // Model: release one cycle after the first eligible WAIT cycle; residence judged there.
      delta = t_wait - elig;
      if (!delta[TW-1]) first_t = t_wait + 1;
      else begin
         first_t = elig + 1;
         delta   = '0;
      end
      drop   = (delta > TW'(MAXR));
      idx    = 0;
      active = 1'b0;
      guard  = 0;
      while (idx < nbeats && guard < 300) begin
         m_axis_tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         s_axis_tvalid = (rnd && active) ? 1'($urandom_range(0, 1)) : 1'b1;
         {s_axis_tlast, s_axis_tdata} = sent[idx];
         #1;
         if (!active && (drop ? s_axis_tready : m_axis_tvalid)) begin
            active = 1'b1;
            chk("release_time", tmr, first_t);
            if (kill_en) enable = 1'b0;
         end
         if (!active) chk("hold_s_tready", TW'(s_axis_tready), 0);
         if (drop || !active) chk("no_m_tvalid", TW'(m_axis_tvalid), 0);
         if (active && !drop) begin
            chk("mirror_ready", TW'(s_axis_tready), TW'(m_axis_tready));
            chk("mirror_valid", TW'(m_axis_tvalid), TW'(s_axis_tvalid));
         end
         if (m_axis_tvalid && m_axis_tready) got.push_back({m_axis_tlast, m_axis_tdata});
         if (s_axis_tvalid && s_axis_tready) idx++;
         tick();
         guard++;
      end
      s_axis_tvalid = 1'b0;
      chk("frame_bound", TW'(guard < 300), 1);
      chk("frame_started", TW'(active), 1);
      if (drop) exp_drop = (exp_drop < CMAX) ? exp_drop + 1 : CMAX;
      else      exp_pass = (exp_pass < CMAX) ? exp_pass + 1 : CMAX;
      #1;
      chk("idle_after_frame", TW'(busy), 0);
      chk_counters("frame");
      chk("beats_out", TW'(got.size()), drop ? 0 : TW'(nbeats));
      if (!drop && got.size() == nbeats)
         for (int i = 0; i < nbeats; i++) chk("beat_data", TW'(got[i]), TW'(sent[i]));
   endtask

   initial begin
      all1          = '1;
      tmr           = '0;
      rst           = 1'b1;
      enable        = 1'b0;
      s_elig_tdata  = '0;
      s_elig_tvalid = 1'b1;
      s_axis_tdata  = 8'hA5;
      s_axis_tvalid = 1'b1;
      s_axis_tlast  = 1'b1;
      m_axis_tready = 1'b1;
      repeat (3) tick();
      #1;
      chk("rst_busy", TW'(busy), 0);
      chk("rst_elig_tready_en0", TW'(s_elig_tready), 0);
      chk("rst_s_tready", TW'(s_axis_tready), 0);
      chk("rst_m_tvalid", TW'(m_axis_tvalid), 0);
      chk("rst_m_tlast", TW'(m_axis_tlast), 0);
      chk_counters("rst");
      enable = 1'b1;
      #1;
      chk("rst_elig_tready_en1", TW'(s_elig_tready), 1);
      s_elig_tvalid = 1'b0;
      s_axis_tvalid = 1'b0;
      rst           = 1'b0;
      tick();

      // Future eligibility, past within limit, past beyond limit, then a normal frame.
      tmr = 99; run_frame(105, 4, 1'b0, 1'b0);
      tmr = 99; run_frame(50, 4, 1'b0, 1'b0);
      tmr = 99; run_frame(10, 3, 1'b0, 1'b0);
      tmr = 99; run_frame(100, 2, 1'b0, 1'b0);

      // Wrap-around of the 72-bit timer.
      tmr = all1 - 4; run_frame(all1 - 1, 2, 1'b0, 1'b0);
      tmr = all1 - 1; run_frame(72'd1, 1, 1'b0, 1'b0);

      // Single-beat drop, then enable dropped mid-frame.
      tmr = 499; run_frame(300, 1, 1'b0, 1'b0);
      tmr = 599; run_frame(590, 5, 1'b1, 1'b1);
      s_elig_tdata  = tmr;
      s_elig_tvalid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("en0_elig_tready", TW'(s_elig_tready), 0);
         chk("en0_busy", TW'(busy), 0);
         tick();
      end
      s_elig_tvalid = 1'b0;
      enable        = 1'b1;
      run_frame(tmr + 3, 3, 1'b0, 1'b0);

      // Randomized frames with backpressure and valid gaps.
      for (int f = 0; f < 8; f++) begin
         repeat ($urandom_range(0, 2)) tick();
         run_frame(tmr + 1 - 90 + TW'($urandom_range(0, 105)), $urandom_range(1, 5), 1'b1,
                   1'b0);
      end

      // Reset in the middle of a passing frame.
      tmr           = 199;
      s_elig_tdata  = 150;
      s_elig_tvalid = 1'b1;
      tick();
      s_elig_tvalid = 1'b0;
      tick();
      s_axis_tvalid = 1'b1;
      s_axis_tlast  = 1'b0;
      s_axis_tdata  = 8'h3C;
      m_axis_tready = 1'b1;
      #1;
      chk("pre_rst_m_tvalid", TW'(m_axis_tvalid), 1);
      tick();
      rst = 1'b1;
      s_axis_tlast = 1'b1;
      tick();
      #1;
      exp_pass = 0;
      exp_drop = 0;
      chk("midrst_busy", TW'(busy), 0);
      chk("midrst_s_tready", TW'(s_axis_tready), 0);
      chk("midrst_m_tvalid", TW'(m_axis_tvalid), 0);
      chk("midrst_m_tlast", TW'(m_axis_tlast), 0);
      chk("midrst_elig_tready", TW'(s_elig_tready), 1);
      chk_counters("midrst");
      rst           = 1'b0;
      s_axis_tvalid = 1'b0;
      tick();

      // Saturation: five passes leave a 2-bit counter at 3.
      for (int f = 0; f < 5; f++) run_frame(tmr + 1, 1 + f % 2, 1'b0, 1'b0);
      chk("sat_pass_count", TW'(pass_count), 3);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/ats_eligibility_gate.md
# ats_eligibility_gate

Per-queue ATS transmission controller. It sits between a frame FIFO and the egress selector, and pairs each queued frame with its eligibility time, read from a separate metadata stream. It holds the frame until the ATS scheduler timer reaches that time, then releases exactly one frame. A frame whose residence exceeds the configured limit is discarded instead. Pass and drop counters are exposed for management.

## Interface
- `DATA_WIDTH`, default 8: frame beat width.
- `TIMESTAMP_WIDTH`, default 72: width of the timer and of eligibility times.
- `MAX_RESIDENCE_TIME`, default 0: maximum allowed (timer − eligibility time) when a frame is released. 0 disables the drop check.
- `COUNTER_WIDTH`, default 32: width of the pass and drop counters.

Ports:
- `clk`  in  1  single clock for all logic.
- `rst`  in  1  synchronous, active-high reset.
- `ats_scheduler_timer`  in  TIMESTAMP_WIDTH  free-running ATS time.
- `enable`  in  1  when 0, no new eligibility record is accepted. A frame already in progress completes normally.
- `s_elig_tdata`  in  TIMESTAMP_WIDTH  eligibility time, one beat per frame.
- `s_elig_tvalid`  in  1  eligibility record valid.
- `s_elig_tready`  out  1  eligibility record accepted.
- `s_axis_tdata`  in  DATA_WIDTH  frame data.
- `s_axis_tvalid`  in  1  frame data valid.
- `s_axis_tready`  out  1  frame data accepted.
- `s_axis_tlast`  in  1  last beat of a frame.
- `m_axis_tdata`  out  DATA_WIDTH  released frame data.
- `m_axis_tvalid`  out  1  released frame valid.
- `m_axis_tready`  in  1  downstream ready.
- `m_axis_tlast`  out  1  last beat of a released frame.
- `pass_count`  out  COUNTER_WIDTH  number of frames released, saturating.
- `drop_count`  out  COUNTER_WIDTH  number of frames dropped, saturating.
- `busy`  out  1  1 in any state other than IDLE.

## Operation
The FSM has four states: IDLE, WAIT, PASS and DROP.

- **IDLE**
  - `s_elig_tready = enable`.
  - On `s_elig_tvalid & s_elig_tready`: latch `s_elig_tdata` into `elig_time` and go to WAIT.
  - `s_axis_tready = 0` and `m_axis_tvalid = 0`.
- **WAIT**
  - Compute `delta = ats_scheduler_timer − elig_time`, modulo 2^TIMESTAMP_WIDTH.
  - The frame is eligible when `delta[TIMESTAMP_WIDTH-1] == 0`. This is a wrap-safe compare: timer ≥ elig_time within half the range.
  - If eligible and (`MAX_RESIDENCE_TIME == 0` or `delta <= MAX_RESIDENCE_TIME`), go to PASS.
  - If eligible and `delta > MAX_RESIDENCE_TIME`, go to DROP.
  - Otherwise stay in WAIT.
  - `s_axis_tready = 0` and `m_axis_tvalid = 0`; frame data is held untouched in the upstream FIFO.
- **PASS** (combinational pass-through)
  - `m_axis_tdata/tvalid/tlast = s_axis_*`.
  - `s_axis_tready = m_axis_tready`.
  - On `s_axis_tvalid & s_axis_tready & s_axis_tlast`: increment `pass_count` and go to IDLE.
- **DROP**
  - `s_axis_tready = 1` and `m_axis_tvalid = 0`; beats are consumed and discarded.
  - On the tlast handshake: increment `drop_count` and go to IDLE.
- **Counters**
  - Each counter saturates at all-ones and never wraps.
  - Each counter increments by at most 1 per cycle.
- **enable**
  - `enable` only gates the IDLE acceptance. Deasserting it in WAIT, PASS or DROP has no effect until the FSM returns to IDLE.
- **Residence check timing**
  - The check is evaluated only in the cycle the frame becomes eligible. Once in PASS, downstream backpressure never converts the frame into a drop.
- **Frame boundaries**
  - A single-beat frame (tlast on the first beat) is valid in both PASS and DROP.

## Timing
- **Reset values**
  - State is IDLE and `elig_time` is 0.
  - `pass_count` and `drop_count` are 0.
  - `busy = 0`.
  - `s_elig_tready = enable`, so it is 0 when `enable` is low.
  - `s_axis_tready = 0`, `m_axis_tvalid = 0`, `m_axis_tlast = 0`.
- **Reset mid-frame**
  - The FSM returns to IDLE and the remainder of the frame is not tracked.
  - Upstream FIFO flush is the integrator's responsibility.
- **Release latency**
  - Eligibility record accepted at edge N: WAIT during cycle N+1.
  - If the timer is already ≥ `elig_time` in cycle N+1, the state is PASS in cycle N+2 and the first beat can transfer in cycle N+2.
  - In general, the first beat can transfer one cycle after the first WAIT cycle in which the frame is eligible.
- **Turnaround**
  - The tlast handshake at edge M puts the FSM in IDLE in cycle M+1; the next eligibility record can be accepted at edge M+1.
  - Minimum gap between frames is therefore 2 idle cycles on `m_axis`.
- **Pass-through**
  - PASS adds zero latency and no bubbles: with continuous valid/ready, one beat transfers per cycle.
- **Simultaneous events**
  - `s_axis_tvalid` asserted while in IDLE or WAIT is ignored; `s_axis_tready = 0`.
  - `s_elig_tvalid` while not in IDLE is ignored; `s_elig_tready = 0`.
- **Counter visibility**
  - A counter update is visible in the cycle after the tlast handshake.

## Test plan
- **Future eligibility:** timer=100, elig=105, 4-beat frame with `m_axis_tready` tied 1 → no `m_axis_tvalid` while timer < 105; first beat on `m_axis` in the cycle after the timer reaches 105; 4 beats contiguous, tlast on the 4th; `pass_count=1`.
- **Past, within limit:** elig=50, timer=100, MAX_RESIDENCE_TIME=64 → PASS; output beats identical to input; `drop_count=0`.
- **Past, beyond limit:** elig=10, timer=100, MAX_RESIDENCE_TIME=64 → DROP; 3-beat frame consumed with `m_axis_tvalid=0` throughout; `drop_count=1`; next frame (elig=100) passes normally.
- **Wrap-around:** TIMESTAMP_WIDTH=72, elig=2^72−2, timer starting at 2^72−4 → WAIT for 2 cycles until timer reaches 2^72−2; elig=1, timer=2^72−1 → WAIT until the timer wraps to 1; then PASS.
- **Backpressure and enable:** `m_axis_tready` toggles 1/0 during PASS → `s_axis_tready` mirrors it and no beat is lost or duplicated. Deassert `enable` mid-frame → the frame completes; the next record is not accepted until `enable=1`.
- **Reset and saturation:** `rst` asserted in PASS → next cycle IDLE, all outputs at their reset values, counters 0. With COUNTER_WIDTH=2, pass 5 frames → `pass_count` stays at 3.
